// File: rtl/score_event_tx.sv
// Score event transmitter: queues award points and emits one paced score_signal toggle per point.
// Latency: a hit into an idle block with nothing pending toggles score_signal two edges later; toggles are HOLD_CYCLES apart.
// No backpressure: hits always queue, the pending counter saturates and sets overflow. Option: SCORE_TX_STATS_EN adds total_sent.
module score_event_tx #(
  parameter int PEND_W      = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              hit,
  input  logic [3:0]        hit_points,
  input  logic              game_over,
  output logic              score_signal,
  output logic [3:0]        get_score,
  output logic              game_end,
  output logic              busy,
  output logic              overflow
`ifdef SCORE_TX_STATS_EN
  ,
  output logic [13:0]       total_sent
`endif
);

  localparam int GAP_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(HOLD_CYCLES - 2);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {IDLE, TOGGLE, GAP, DONE} state_t;

  state_t            state, state_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic [PEND_W-1:0] pending;
  logic              end_req;
  logic              accept;
  logic [PEND_W:0]   add_ext;
  logic [PEND_W:0]   sum_ext;

  // An award is taken only while the game is still running and no end has been requested.
  always_comb begin
    accept  = hit && (hit_points != 4'd0) && !game_end && !end_req;
    add_ext = '0;
    if (accept) add_ext = (PEND_W + 1)'(hit_points);
    sum_ext = {1'b0, pending} + add_ext - {{PEND_W{1'b0}}, (state == TOGGLE)};
  end

  // Next-state logic; a gap of HOLD_CYCLES-1 cycles keeps toggles exactly HOLD_CYCLES apart.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: begin
        if (pending != '0)  state_nxt = TOGGLE;
        else if (end_req)   state_nxt = DONE;
      end
      TOGGLE: begin
        state_nxt   = GAP;
        gap_cnt_nxt = GAP_LOAD;
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = (pending != '0) ? TOGGLE : IDLE;
        else               gap_cnt_nxt = gap_cnt - 1'b1;
      end
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and gap counter registers; clear returns the FSM to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else if (clear) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Pending points, award bookkeeping and the toggle line; clear keeps the line level so no point is sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      overflow     <= 1'b0;
      get_score    <= 4'd0;
      end_req      <= 1'b0;
      game_end     <= 1'b0;
      score_signal <= 1'b0;
    end else if (clear) begin
      pending      <= '0;
      overflow     <= 1'b0;
      get_score    <= 4'd0;
      end_req      <= 1'b0;
      game_end     <= 1'b0;
    end else begin
      if (sum_ext[PEND_W]) begin
        pending  <= PEND_MAX;
        overflow <= 1'b1;
      end else begin
        pending  <= sum_ext[PEND_W-1:0];
      end
      if (accept)          get_score    <= hit_points;
      if (game_over)       end_req      <= 1'b1;
      game_end <= (state == DONE);
      if (state == TOGGLE) score_signal <= ~score_signal;
    end
  end

`ifdef SCORE_TX_STATS_EN
  // Count transmitted points with the same 0..9999 wrap as the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  total_sent <= 14'd0;
    else if (clear)           total_sent <= 14'd0;
    else if (state == TOGGLE) total_sent <= (total_sent == 14'd9999) ? 14'd0 : total_sent + 14'd1;
  end
`endif

  assign busy = (pending != '0) || (state == TOGGLE) || (state == GAP);

endmodule

// File: tb/tb_score_event_tx.sv
// Bench for score_event_tx: directed scenarios plus random traffic against a cycle reference model.
// Inputs change on the falling edge, outputs are compared on the falling edge.
// Pending counter is 4 bits wide here so saturation is reachable.
module tb_score_event_tx;
  localparam int PW   = 4;
  localparam int HOLD = 16;
  localparam int PMAX = 15;

  logic       clk = 1'b0;
  logic       rst, clear, hit, game_over;
  logic [3:0] hit_points;
  logic       score_signal, game_end, busy, overflow;
  logic [3:0] get_score;
`ifdef SCORE_TX_STATS_EN
  logic [13:0] total_sent;
`endif

  score_event_tx #(.PEND_W(PW), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .clear(clear), .hit(hit), .hit_points(hit_points),
    .game_over(game_over), .score_signal(score_signal), .get_score(get_score),
    .game_end(game_end), .busy(busy), .overflow(overflow)
`ifdef SCORE_TX_STATS_EN
    , .total_sent(total_sent)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: phase 0 waiting, 1 sending a point, 2 spacing, 3 finished
  int       m_ph, m_since, m_pend, m_sent;
  bit       m_sig, m_ovf, m_end_req, m_gend;
  bit [3:0] m_gs;
  int       toggles;
  logic     prev_sig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_since = 0; m_pend = 0; m_sent = 0;
    m_sig = 0; m_ovf = 0; m_end_req = 0; m_gend = 0; m_gs = 0;
    prev_sig = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at that edge.
  task automatic model_edge();
    int  np, nph, nsince;
    bit  acc;
    if (clear) begin
      m_ph = 0; m_since = 0; m_pend = 0; m_end_req = 0; m_gend = 0; m_ovf = 0; m_gs = 0;
    end else begin
      acc = hit && (hit_points != 0) && !m_gend && !m_end_req;
      np  = m_pend + (acc ? int'(hit_points) : 0) - ((m_ph == 1) ? 1 : 0);
      nph = m_ph; nsince = m_since;
      case (m_ph)
        0: if (m_pend > 0) nph = 1; else if (m_end_req) nph = 3;
        1: begin m_sig = ~m_sig; m_sent = (m_sent + 1) % 10000; nph = 2; nsince = 1; end
        2: if (m_since == HOLD - 1) nph = (m_pend > 0) ? 1 : 0; else nsince = m_since + 1;
        default: nph = 3;
      endcase
      m_gend = (m_ph == 3);
      if (np > PMAX) begin np = PMAX; m_ovf = 1; end
      m_pend = np;
      if (acc) m_gs = hit_points;
      if (game_over) m_end_req = 1;
      m_ph = nph; m_since = nsince;
    end
  endtask

  task automatic check_all();
    chk("score_signal", 32'(score_signal), 32'(m_sig));
    chk("get_score", 32'(get_score), 32'(m_gs));
    chk("game_end", 32'(game_end), 32'(m_gend));
    chk("busy", 32'(busy), 32'((m_pend != 0) || m_ph == 1 || m_ph == 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SCORE_TX_STATS_EN
    chk("total_sent", 32'(total_sent), 32'(m_sent));
`endif
  endtask

  task automatic cyc(input bit h, input logic [3:0] p, input bit go, input bit clr);
    hit = h; hit_points = p; game_over = go; clear = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (score_signal !== prev_sig) toggles++;
    prev_sig = score_signal;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'd0, 0, 0);
  endtask

  initial begin
    int t0;
    logic s0;
    rst = 1'b1; clear = 1'b0; hit = 1'b0; hit_points = 4'd0; game_over = 1'b0;
    toggles = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // single award: first toggle at E2, then HOLD apart
    t0 = toggles;
    cyc(1, 4'd3, 0, 0);
    chk("e0_no_toggle", 32'(score_signal), 32'd0);
    idle(2);
    chk("e2_toggle", 32'(score_signal), 32'd1);
    idle(HOLD - 1);
    chk("spacing_hold", 32'(score_signal), 32'd1);
    idle(1);
    chk("second_toggle", 32'(score_signal), 32'd0);
    idle(60);
    chk("single_count", 32'(toggles - t0), 32'd3);
    chk("single_gs", 32'(get_score), 32'd3);
    chk("single_busy", 32'(busy), 32'd0);

    // back-to-back awards
    t0 = toggles;
    cyc(1, 4'd2, 0, 0);
    idle(5);
    cyc(1, 4'd5, 0, 0);
    idle(140);
    chk("b2b_count", 32'(toggles - t0), 32'd7);
    chk("b2b_gs", 32'(get_score), 32'd5);

    // zero-point hit is ignored
    t0 = toggles;
    cyc(1, 4'd0, 0, 0);
    idle(30);
    chk("zero_count", 32'(toggles - t0), 32'd0);
    chk("zero_gs", 32'(get_score), 32'd5);

    // game over drains pending points, later hits ignored
    t0 = toggles;
    cyc(1, 4'd4, 0, 0);
    cyc(0, 4'd0, 1, 0);
    idle(100);
    chk("drain_count", 32'(toggles - t0), 32'd4);
    chk("drain_end", 32'(game_end), 32'd1);
    t0 = toggles;
    cyc(1, 4'd9, 0, 0);
    idle(40);
    chk("done_count", 32'(toggles - t0), 32'd0);
    chk("done_gs", 32'(get_score), 32'd4);

    // clear leaves the line level alone
    s0 = score_signal;
    cyc(0, 4'd0, 0, 1);
    chk("clear_end", 32'(game_end), 32'd0);
    chk("clear_sig", 32'(score_signal), 32'(s0));

    // saturation
    t0 = toggles;
    cyc(1, 4'd15, 0, 0);
    cyc(1, 4'd15, 0, 0);
    idle(2);
    chk("sat_ovf", 32'(overflow), 32'd1);
    idle(300);
    chk("sat_count", 32'(toggles - t0), 32'd15);
    s0 = score_signal;
    cyc(0, 4'd0, 0, 1);
    chk("sat_clear_ovf", 32'(overflow), 32'd0);
    chk("sat_clear_sig", 32'(score_signal), 32'(s0));

    // asynchronous reset in the middle of a gap
    cyc(1, 4'd3, 0, 0);
    idle(8);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_sig", 32'(score_signal), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_gs", 32'(get_score), 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    t0 = toggles;
    idle(60);
    chk("post_rst_count", 32'(toggles - t0), 32'd0);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      bit h, go, clr;
      h   = ($urandom_range(0, 19) == 0);
      go  = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 399) == 0);
      cyc(h, 4'($urandom_range(0, 15)), go, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
